// File: rtl/hazard_pkg.sv
// hazard_pkg: shared state encoding and constants for the hazard/control unit.
package hazard_pkg;
    typedef enum logic {RUN = 1'b0, MUL_WAIT = 1'b1} state_t;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0020;
    localparam logic [4:0]  REG_ZERO  = 5'd0;
endpackage

// File: rtl/mul_stall_timer.sv
// mul_stall_timer: holds a multiply in EX for MUL_LAT cycles, flagging the stall cycles and the final done cycle.
module mul_stall_timer
    import hazard_pkg::*;
#(
    parameter int MUL_LAT = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    output logic stall_o,
    output logic done_o
);
    localparam int CW = $clog2(MUL_LAT);

    state_t r_state, w_next_state;
    logic [CW-1:0] r_cnt, w_next_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // start_i is only sampled in RUN; the held multiply keeps it high while waiting
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        if (r_state == RUN) begin
            if (start_i) begin
                w_next_state = MUL_WAIT;
                w_next_cnt   = CW'(MUL_LAT - 2);
            end
        end else if (r_cnt != '0) begin
            w_next_cnt = r_cnt - 1'b1;
        end else begin
            w_next_state = RUN;
        end
    end

    always_comb begin
        stall_o = (r_state == RUN) ? start_i : (r_cnt != '0);
        done_o  = (r_state == MUL_WAIT) && (r_cnt == '0);
    end
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use / branch-flush / multiply-stall control for the 5-stage pipeline registers.
// Optional saturating stall/flush counters when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       id_rs_i,
    input  logic [4:0]       id_rt_i,
    input  logic             id_uses_rt_i,
    input  logic             id_branch_taken_i,
    input  logic             ex_mem_read_i,
    input  logic [4:0]       ex_rt_i,
    input  logic             ex_mul_start_i,
    output logic             pc_write_o,
    output logic             if_id_stall_o,
    output logic             if_id_flush_o,
    output logic             id_ex_bubble_o,
    output logic             ex_stall_o,
    output logic             mem_bubble_o,
    output logic             mul_done_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);
    logic w_mul_stall, w_mul_done, w_load_use;

    mul_stall_timer #(.MUL_LAT(MUL_LAT)) u_mul_timer (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (ex_mul_start_i),
        .stall_o (w_mul_stall),
        .done_o  (w_mul_done)
    );

    assign w_load_use = ex_mem_read_i && (ex_rt_i != REG_ZERO) &&
                        ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));

    // multiply stall outranks load-use, which outranks the branch flush
    always_comb begin
        if_id_stall_o  = w_mul_stall || w_load_use;
        pc_write_o     = !if_id_stall_o;
        id_ex_bubble_o = w_load_use && !w_mul_stall;
        if_id_flush_o  = id_branch_taken_i && !if_id_stall_o;
        ex_stall_o     = w_mul_stall;
        mem_bubble_o   = w_mul_stall;
        mul_done_o     = w_mul_done;
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (if_id_stall_o && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + 1'b1;
            if (if_id_flush_o && !(&r_flush_cnt)) r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif
endmodule
